tlb_walker: RTL
===============

Name: tlb_walker

Overview:
- Hardware page-table walker that sits directly downstream of the TLB set array.
- On a TLB miss it reads the radix page table through a memory read port, level by level.
- It then returns a refill (VPN, PCID, PPN) or a fault to the TLB fill path.
- Handles one walk at a time; valid/ready handshakes on all three interfaces.

Parameters:
ADDR, 64, virtual/physical address width in bits
PAGE, 12, page offset bits; must equal IDX+3 (8-byte PTEs, one table per page)
PCID, 12, process-context ID width
LEVELS, 4, page-table levels; level 0 = root
IDX, 9, VPN index bits consumed per level

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
miss_valid  in  1  TLB miss request
miss_ready  out  1  walker can accept a miss
miss_vaddr  in  ADDR  missing virtual address
miss_pcid  in  PCID  PCID of the miss
root_ppn  in  ADDR-PAGE  root table PPN, sampled with the miss
flush  in  1  abandon current walk, no fill
mem_req_valid  out  1  PTE read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR  PTE byte address
mem_rsp_valid  in  1  PTE data valid (one cycle, one per accepted request)
mem_rsp_data  in  64  PTE: bit0 present, bits[ADDR-1:PAGE] next/leaf PPN
fill_valid  out  1  refill result valid
fill_ready  in  1  TLB accepts refill
fill_vpn  out  ADDR-PAGE  miss_vaddr[ADDR-1:PAGE]
fill_pcid  out  PCID  PCID of the walk
fill_ppn  out  ADDR-PAGE  leaf PPN (0 on fault)
fill_fault  out  1  walk hit a non-present PTE

Behaviour:
- Reset (async, rst_n=0): state IDLE, level=0, drop=0, all data registers 0.
- Reset values: miss_ready=1, mem_req_valid=0, fill_valid=0, fill_fault=0, mem_req_addr=0, fill_vpn/pcid/ppn=0.
- Reset mid-walk aborts immediately. Any later mem_rsp_valid in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE. Registers: vaddr, pcid, table_ppn, level (clog2(LEVELS) bits), drop.
- IDLE: miss_ready=1. On miss_valid & ~flush, latch vaddr, pcid and table_ppn=root_ppn, set level=0 -> REQ. miss_ready=0 in all other states.
- REQ:
  - mem_req_valid=1; mem_req_addr = {table_ppn, idx(level), 3'b000}.
  - idx(L) = vaddr[PAGE+IDX*(LEVELS-L)-1 : PAGE+IDX*(LEVELS-L-1)].
  - Bits of vaddr above PAGE+IDX*LEVELS are not used for indexing.
  - Address is held stable until mem_req_valid & mem_req_ready -> WAIT.
  - flush in REQ before acceptance -> IDLE, no fill.
- WAIT:
  - Waits for mem_rsp_valid. A response cannot arrive in the acceptance cycle; the earliest is the following cycle.
  - flush in WAIT sets drop=1; the walker still consumes the outstanding response.
  - On response with drop=1 -> IDLE, no fill.
  - Otherwise, with present=0: fault=1, ppn=0 -> DONE.
  - Otherwise, with level==LEVELS-1: ppn=mem_rsp_data[ADDR-1:PAGE], fault=0 -> DONE.
  - Otherwise: table_ppn=mem_rsp_data[ADDR-1:PAGE], level+1 -> REQ.
- DONE: fill_valid=1 with fill_* stable until fill_ready. On fill_ready -> IDLE; miss_ready=1 next cycle. flush in DONE is ignored (result already final).
- Latency with zero-wait memory (ready=1, rsp the cycle after accept):
  - miss accepted at T; level-0 request at T+1; each level takes 2 cycles.
  - fill_valid at T+1+2*LEVELS (T+9 by default).
- Simultaneous miss_valid & flush in IDLE: flush wins, miss not accepted.

Test Plan:
- Full walk, zero-wait: root_ppn=0x100, vaddr=0x80_4020_1ABC, pcid=0x005.
  - mem_req_addr sequence 0x100008, 0x200008, 0x300008, 0x400008, given PTEs 0x200001, 0x300001, 0x400001, 0x555001.
  - Expect fill_valid at T+9 with fill_vpn=0x8040201, fill_ppn=0x555, fill_pcid=0x005, fill_fault=0.
- Fault at level 1: same setup, second PTE=0x0 -> exactly two memory requests, fill_fault=1, fill_ppn=0, then IDLE.
- Backpressure: mem_req_ready low for 3 cycles at each level and fill_ready low for 2 cycles -> mem_req_addr and fill_* stay stable, miss_ready=0 throughout, result identical to the first test.
- Flush in WAIT at level 2: flush pulses while the response is outstanding -> response consumed, no fill_valid, miss_ready=1 the cycle after the response, next miss walks correctly.
- Async reset mid-walk: rst_n low while in WAIT at level 1.
  - Outputs go to reset values immediately.
  - A stray mem_rsp_valid after reset release is ignored.
  - A new miss completes normally.
- Back-to-back misses: second miss_valid held during the first walk -> accepted only in the cycle after the first fill handshake.

Source files
------------

// File: rtl/tlb_walker.sv
// Radix page-table walker: turns a TLB miss into a chain of PTE reads, one level
// at a time, and hands back either a leaf translation or a fault to the fill path.
module tlb_walker #(
  parameter int ADDR   = 64,
  parameter int PAGE   = 12,
  parameter int PCID   = 12,
  parameter int LEVELS = 4,
  parameter int IDX    = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_miss_valid,
  output logic                 o_miss_ready,
  input  logic [ADDR-1:0]      i_miss_vaddr,
  input  logic [PCID-1:0]      i_miss_pcid,
  input  logic [ADDR-PAGE-1:0] i_root_ppn,
  input  logic                 i_flush,
  output logic                 o_mem_req_valid,
  input  logic                 i_mem_req_ready,
  output logic [ADDR-1:0]      o_mem_req_addr,
  input  logic                 i_mem_rsp_valid,
  input  logic [63:0]          i_mem_rsp_data,
  output logic                 o_fill_valid,
  input  logic                 i_fill_ready,
  output logic [ADDR-PAGE-1:0] o_fill_vpn,
  output logic [PCID-1:0]      o_fill_pcid,
  output logic [ADDR-PAGE-1:0] o_fill_ppn,
  output logic                 o_fill_fault
);

  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ADDR-1:0]      r_vaddr;
  logic [PCID-1:0]      r_pcid;
  logic [ADDR-PAGE-1:0] r_table_ppn;
  logic [ADDR-PAGE-1:0] r_ppn;
  logic [LVL_W-1:0]     r_level;
  logic                 r_drop;
  logic                 r_fault;

  logic [IDX-1:0]       w_idx [LEVELS];
  logic [IDX-1:0]       w_idx_sel;
  logic                 w_accept;
  logic                 w_req_fire;
  logic                 w_last;
  logic                 w_present;
  logic                 w_drop_now;
  logic [ADDR-PAGE-1:0] w_rsp_ppn;

  // Level 0 consumes the most significant VPN slice; bits above the top slice are ignored.
  generate
    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_idx
      assign w_idx[gi] = r_vaddr[PAGE+IDX*(LEVELS-gi)-1 -: IDX];
    end
  endgenerate

  assign w_idx_sel  = w_idx[r_level];
  assign w_accept   = (r_state == S_IDLE) && i_miss_valid && !i_flush;
  assign w_req_fire = (r_state == S_REQ) && i_mem_req_ready;
  assign w_last     = (r_level == LVL_W'(LEVELS-1));
  assign w_present  = i_mem_rsp_data[0];
  assign w_drop_now = r_drop || i_flush;
  assign w_rsp_ppn  = i_mem_rsp_data[ADDR-1:PAGE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    o_miss_ready    = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    o_fill_valid    = 1'b0;
    o_fill_vpn      = '0;
    o_fill_pcid     = '0;
    o_fill_ppn      = '0;
    o_fill_fault    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_miss_ready = 1'b1;
        if (w_accept) w_state_next = S_REQ;
      end
      S_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_addr  = {r_table_ppn, w_idx_sel, 3'b000};
        // A request taken by memory must have its response consumed, so acceptance beats flush.
        if (i_mem_req_ready)  w_state_next = S_WAIT;
        else if (i_flush)     w_state_next = S_IDLE;
      end
      S_WAIT: begin
        if (i_mem_rsp_valid) begin
          if (w_drop_now)              w_state_next = S_IDLE;
          else if (!w_present || w_last) w_state_next = S_DONE;
          else                         w_state_next = S_REQ;
        end
      end
      S_DONE: begin
        o_fill_valid = 1'b1;
        o_fill_vpn   = r_vaddr[ADDR-1:PAGE];
        o_fill_pcid  = r_pcid;
        o_fill_ppn   = r_ppn;
        o_fill_fault = r_fault;
        if (i_fill_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vaddr     <= '0;
      r_pcid      <= '0;
      r_table_ppn <= '0;
      r_ppn       <= '0;
      r_level     <= '0;
      r_drop      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_vaddr     <= i_miss_vaddr;
            r_pcid      <= i_miss_pcid;
            r_table_ppn <= i_root_ppn;
            r_level     <= '0;
            r_drop      <= 1'b0;
            r_fault     <= 1'b0;
            r_ppn       <= '0;
          end
        end
        S_REQ: begin
          if (w_req_fire && i_flush) r_drop <= 1'b1;
        end
        S_WAIT: begin
          if (i_flush) r_drop <= 1'b1;
          if (i_mem_rsp_valid) begin
            r_drop <= 1'b0;
            if (!w_drop_now) begin
              if (!w_present) begin
                r_fault <= 1'b1;
                r_ppn   <= '0;
              end else if (w_last) begin
                r_fault <= 1'b0;
                r_ppn   <= w_rsp_ppn;
              end else begin
                r_table_ppn <= w_rsp_ppn;
                r_level     <= r_level + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
